// File: rtl/receiver_pkg.sv
// Shared letter-buffer definitions: letter code width, letter type and the
// read-port latency of the letter storage.
package receiver_pkg;

    localparam int unsigned LETTER_W   = 5;
    localparam int unsigned RD_LATENCY = 2;

    typedef logic [LETTER_W-1:0] letter_t;

endpackage

// File: rtl/letter_ram.sv
// Simple dual-port letter storage: port A writes, port B reads with two
// registered stages (read-first on a same-address collision).
module letter_ram #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_a_we,
    input  logic [$clog2(DEPTH)-1:0] i_a_addr,
    input  logic [WIDTH-1:0]         i_a_data,
    input  logic                     i_b_re,
    input  logic [$clog2(DEPTH)-1:0] i_b_addr,
    output logic [WIDTH-1:0]         o_b_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_b_re) begin
            r_q1 <= r_mem[i_b_addr];
        end
        r_q2 <= r_q1;
    end

    assign o_b_data = r_q2;

endmodule

// File: rtl/letter_ring_buffer.sv
// Circular letter buffer with stream pop and history lookup sharing one read port.
// Optional LETTER_RING_BUFFER_STATS_EN adds drop_count_out (dropped/overwritten letters).
module letter_ring_buffer
    import receiver_pkg::*;
#(
    parameter int WIDTH     = LETTER_W,
    parameter int DEPTH     = 1024,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_valid_in,
    input  logic [WIDTH-1:0]         wr_data_in,
    output logic                     wr_ready_out,
    input  logic                     rd_req_in,
    output logic                     rd_valid_out,
    output logic [WIDTH-1:0]         rd_data_out,
    input  logic                     hist_req_in,
    input  logic [$clog2(DEPTH)-1:0] hist_offset_in,
    output logic                     hist_ready_out,
    output logic                     hist_valid_out,
    output logic                     hist_hit_out,
    output logic [WIDTH-1:0]         hist_data_out,
`ifdef LETTER_RING_BUFFER_STATS_EN
    output logic [15:0]              drop_count_out,
`endif
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     full_out,
    output logic                     empty_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [AW:0]           r_count;
    logic                  r_full;
    logic                  r_empty;
    logic [RD_LATENCY-1:0] r_rd_pipe;
    logic [RD_LATENCY-1:0] r_hist_pipe;
    logic [RD_LATENCY-1:0] r_hit_pipe;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovw;
    logic                  w_hist_acc;
    logic                  w_hist_hit;
    logic [AW-1:0]         w_hist_addr;
    logic [AW-1:0]         w_rd_addr;
    logic [AW:0]           w_count_next;
    logic [WIDTH-1:0]      w_ram_q;

    assign wr_ready_out   = (OVERWRITE != 0) ? 1'b1 : !r_full;
    assign hist_ready_out = !rd_req_in;

    always_comb begin
        w_wr_acc    = wr_valid_in && wr_ready_out;
        w_rd_acc    = rd_req_in && !r_empty;
        // A full write alongside a pop replaces the popped slot, so nothing is lost.
        w_ovw       = w_wr_acc && r_full && !w_rd_acc;
        w_hist_acc  = hist_req_in && hist_ready_out;
        w_hist_hit  = {1'b0, hist_offset_in} < r_count;
        w_hist_addr = r_wp - PTR_ONE - hist_offset_in;
        w_rd_addr   = rd_req_in ? r_rp : w_hist_addr;
        w_count_next = r_count;
        case ({w_wr_acc && !w_ovw, w_rd_acc})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_rd_acc || w_ovw) begin
                r_rp <= r_rp + PTR_ONE;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_pipe   <= '0;
            r_hist_pipe <= '0;
            r_hit_pipe  <= '0;
        end else begin
            r_rd_pipe   <= {r_rd_pipe[RD_LATENCY-2:0], w_rd_acc};
            r_hist_pipe <= {r_hist_pipe[RD_LATENCY-2:0], w_hist_acc};
            r_hit_pipe  <= {r_hit_pipe[RD_LATENCY-2:0], w_hist_acc && w_hist_hit};
        end
    end

    letter_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk    (clk_in),
        .i_a_we   (w_wr_acc),
        .i_a_addr (r_wp),
        .i_a_data (wr_data_in),
        .i_b_re   (w_rd_acc || w_hist_acc),
        .i_b_addr (w_rd_addr),
        .o_b_data (w_ram_q)
    );

    assign rd_valid_out   = r_rd_pipe[RD_LATENCY-1];
    assign hist_valid_out = r_hist_pipe[RD_LATENCY-1];
    assign hist_hit_out   = r_hit_pipe[RD_LATENCY-1];
    assign rd_data_out    = rd_valid_out ? w_ram_q : '0;
    assign hist_data_out  = hist_hit_out ? w_ram_q : '0;

    assign count_out = r_count;
    assign full_out  = r_full;
    assign empty_out = r_empty;

`ifdef LETTER_RING_BUFFER_STATS_EN
    logic [15:0] r_drop;
    logic        w_drop_evt;

    assign w_drop_evt = (OVERWRITE != 0) ? w_ovw : (wr_valid_in && !wr_ready_out);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_drop <= '0;
        end else if (w_drop_evt && (r_drop != '1)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    assign drop_count_out = r_drop;
`endif

endmodule

// File: tb/tb_letter_ring_buffer.sv
// Directed bench for letter_ring_buffer at DEPTH=4: a vector table drives the
// drop-new instance, hand sequences cover the overwrite instance.
module tb_letter_ring_buffer;

    localparam int W  = 5;
    localparam int D  = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wv, rd, hq;
    logic [W-1:0]  wd;
    logic [AW-1:0] ho;

    logic          wrdy_0, rv_0, hrdy_0, hv_0, hh_0, full_0, empty_0;
    logic [W-1:0]  rdat_0, hdat_0;
    logic [AW:0]   cnt_0;
    logic          wrdy_1, rv_1, hrdy_1, hv_1, hh_1, full_1, empty_1;
    logic [W-1:0]  rdat_1, hdat_1;
    logic [AW:0]   cnt_1;
`ifdef LETTER_RING_BUFFER_STATS_EN
    logic [15:0]   drop_0, drop_1;
`endif

    letter_ring_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0)) dut0 (
        .clk_in(clk), .rst_in(rst),
        .wr_valid_in(wv), .wr_data_in(wd), .wr_ready_out(wrdy_0),
        .rd_req_in(rd), .rd_valid_out(rv_0), .rd_data_out(rdat_0),
        .hist_req_in(hq), .hist_offset_in(ho), .hist_ready_out(hrdy_0),
        .hist_valid_out(hv_0), .hist_hit_out(hh_0), .hist_data_out(hdat_0),
`ifdef LETTER_RING_BUFFER_STATS_EN
        .drop_count_out(drop_0),
`endif
        .count_out(cnt_0), .full_out(full_0), .empty_out(empty_0)
    );

    letter_ring_buffer #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1)) dut1 (
        .clk_in(clk), .rst_in(rst),
        .wr_valid_in(wv), .wr_data_in(wd), .wr_ready_out(wrdy_1),
        .rd_req_in(rd), .rd_valid_out(rv_1), .rd_data_out(rdat_1),
        .hist_req_in(hq), .hist_offset_in(ho), .hist_ready_out(hrdy_1),
        .hist_valid_out(hv_1), .hist_hit_out(hh_1), .hist_data_out(hdat_1),
`ifdef LETTER_RING_BUFFER_STATS_EN
        .drop_count_out(drop_1),
`endif
        .count_out(cnt_1), .full_out(full_1), .empty_out(empty_1)
    );

    typedef struct {
        bit          rst, wv;
        int unsigned wd;
        bit          rd, hq;
        int unsigned ho;
        bit          rv;
        int unsigned rdat;
        bit          hv, hh;
        int unsigned hdat, cnt;
        bit          wrdy;
        int unsigned drop;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit w, input int unsigned d, input bit p,
                       input bit h, input int unsigned o, input bit erv,
                       input int unsigned erd, input bit ehv, input bit ehh,
                       input int unsigned ehd, input int unsigned ecnt,
                       input bit ewr, input int unsigned edrop);
        vec_t v;
        v.rst = r; v.wv = w; v.wd = d; v.rd = p; v.hq = h; v.ho = o;
        v.rv = erv; v.rdat = erd; v.hv = ehv; v.hh = ehh; v.hdat = ehd;
        v.cnt = ecnt; v.wrdy = ewr; v.drop = edrop;
        vecs.push_back(v);
    endtask

    task automatic step(input bit r, input bit w, input int unsigned d, input bit p);
        rst = r; wv = w; wd = W'(d); rd = p; hq = 1'b0; ho = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        rst = 1'b0; wv = 1'b0; wd = '0; rd = 1'b0; hq = 1'b0; ho = '0;

        //   rst wv wd rd hq ho | rv rdat hv hh hdat cnt wrdy drop
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 1, 7, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1, 0);
        add(0, 1, 9, 0, 0, 0,   0, 0, 0, 0, 0, 3, 1, 0);
        add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 0,   1, 3, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0,   1, 7, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,   1, 9, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1, 0);
        add(0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 3, 1, 0);
        add(0, 1, 4, 0, 0, 0,   0, 0, 0, 0, 0, 4, 0, 0);
        add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 4, 0, 1);
        add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 3, 1, 1);
        add(0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0, 2, 1, 1);
        add(0, 0, 0, 1, 0, 0,   1, 2, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0,   1, 3, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0,   1, 4, 0, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 1, 2, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1, 1);
        add(0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 0, 3, 1, 1);
        add(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 3, 1, 1);
        add(0, 0, 0, 0, 1, 2,   0, 0, 1, 1, 3, 3, 1, 1);
        add(0, 0, 0, 0, 1, 3,   0, 0, 1, 1, 1, 3, 1, 1);
        add(0, 0, 0, 1, 1, 0,   0, 0, 1, 0, 0, 2, 1, 1);
        add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 2, 1, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 1, 1);
        add(0, 1, 5, 0, 0, 0,   0, 0, 0, 0, 0, 3, 1, 1);
        add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2, 1, 1);
        add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst; wv = v.wv; wd = W'(v.wd); rd = v.rd; hq = v.hq; ho = AW'(v.ho);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.count", i), cnt_0, v.cnt);
            chk($sformatf("v%0d.full", i), full_0, (v.cnt == D) ? 1 : 0);
            chk($sformatf("v%0d.empty", i), empty_0, (v.cnt == 0) ? 1 : 0);
            chk($sformatf("v%0d.wr_ready", i), wrdy_0, v.wrdy);
            chk($sformatf("v%0d.hist_ready", i), hrdy_0, v.rd ? 0 : 1);
            chk($sformatf("v%0d.rd_valid", i), rv_0, v.rv);
            if (v.rv || v.rst) chk($sformatf("v%0d.rd_data", i), rdat_0, v.rdat);
            chk($sformatf("v%0d.hist_valid", i), hv_0, v.hv);
            chk($sformatf("v%0d.hist_hit", i), hh_0, v.hh);
            if (v.hv || v.rst) chk($sformatf("v%0d.hist_data", i), hdat_0, v.hdat);
`ifdef LETTER_RING_BUFFER_STATS_EN
            chk($sformatf("v%0d.drop", i), drop_0, v.drop);
`endif
        end

        // Overwrite mode: 1..6 into four slots keeps the newest four.
        step(1, 0, 0, 0);
        chk("ow.reset_count", cnt_1, 0);
        chk("ow.reset_empty", empty_1, 1);
        chk("ow.reset_full", full_1, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, i, 0);
            chk($sformatf("ow.wr%0d_ready", i), wrdy_1, 1);
            chk($sformatf("ow.wr%0d_count", i), cnt_1, (i < 4) ? i : 4);
        end
        chk("ow.full", full_1, 1);
`ifdef LETTER_RING_BUFFER_STATS_EN
        chk("ow.drop", drop_1, 2);
`endif
        step(0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, (k < 4));
            chk($sformatf("ow.pop%0d_valid", k), rv_1, 1);
            chk($sformatf("ow.pop%0d_data", k), rdat_1, 2 + k);
        end
        chk("ow.drained_count", cnt_1, 0);
        chk("ow.drained_empty", empty_1, 1);

        // Full buffer with write+pop every cycle, wrapping over ten letters.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 1, i, 0);
        chk("wrap.full", full_1, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 5 + i, 1);
            chk($sformatf("wrap.c%0d_count", i), cnt_1, 4);
            chk($sformatf("wrap.c%0d_full", i), full_1, 1);
            if (i > 0) begin
                chk($sformatf("wrap.c%0d_valid", i), rv_1, 1);
                chk($sformatf("wrap.c%0d_data", i), rdat_1, i);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, (k < 4));
            chk($sformatf("wrap.p%0d_valid", k), rv_1, 1);
            chk($sformatf("wrap.p%0d_data", k), rdat_1, 10 + k);
        end
        step(0, 0, 0, 0);
        chk("wrap.end_valid", rv_1, 0);
        chk("wrap.end_empty", empty_1, 1);
`ifdef LETTER_RING_BUFFER_STATS_EN
        chk("wrap.drop", drop_1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
